sram_arbiter: RTL and testbench

- Time-slot arbiter that shares one external 8-bit asynchronous SRAM (256 KB, ROM+RAM image) between three requesters: the video fetch port, the CPU port and the boot/loader port.
- Each 7 MHz pixel period is split into a fixed 8-cycle slot at 56 MHz: a video read phase followed by a CPU or loader phase.
- Sits between the machine core (video address, CPU address/data/write, pe7M0 strobe) and the board-level SRAM pins.
- Tristate buffering is done in the board top.

---
 rtl/sram_arbiter_pkg.sv | 33 +++
 rtl/sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM time-slot arbiter: slot phases, owners, and the
// video-to-physical address mapping that the debug/snapshot logic also uses.
package sram_arbiter_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 8;

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        IDLE = 4'd8
    } phase_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU_RD = 2'd1,
        OWN_CPU_WR = 2'd2,
        OWN_LD_WR  = 2'd3
    } owner_t;

    // RAM sits in the upper 128 KB; screens live in 16 KB pages 5 and 7, and a
    // screen uses only the low 8 KB of its page, hence the zero above the offset.
    function automatic logic [SRAM_AW-1:0] vid_to_phys(input logic [13:0] vid_a);
        return {2'b11, vid_a[13], 1'b1, 1'b0, vid_a[12:0]};
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between video, CPU and loader in fixed 8-clock slots per pixel.
// vidQ valid 3 clocks after sync, cpuQ at t7; no backpressure, losers simply wait a slot.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int AW = SRAM_AW,
    parameter int DW = SRAM_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sync,
    input  logic [13:0]   vidA,
    output logic [7:0]    vidQ,
    input  logic [AW-1:0] cpuA,
    input  logic [DW-1:0] cpuD,
    input  logic          cpuRd,
    input  logic          cpuWr,
    output logic [DW-1:0] cpuQ,
    input  logic          boot,
    input  logic          ldReq,
    input  logic [AW-1:0] ldA,
    input  logic [DW-1:0] ldD,
    output logic          ldAck,
    output logic [AW-1:0] sramA,
    output logic [DW-1:0] sramDo,
    input  logic [DW-1:0] sramDi,
    output logic          sramDrv,
    output logic          sramWe_n,
    output logic          sramOe_n
);

    phase_t phase, phase_nxt;
    owner_t owner, owner_nxt;

    logic [AW-1:0] a_nxt;
    logic [DW-1:0] do_nxt;
    logic          drv_nxt, we_n_nxt, oe_n_nxt, ack_nxt;
    logic [7:0]    vidq_nxt;
    logic [DW-1:0] cpuq_nxt;
    logic          own_write;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= IDLE;
            owner <= OWN_NONE;
        end else begin
            phase <= phase_nxt;
            owner <= owner_nxt;
        end
    end

    // A sync anywhere restarts the slot; a sync at t7 is just the normal wrap.
    always_comb begin
        phase_nxt = phase;
        owner_nxt = owner;
        if (sync)
            phase_nxt = T0;
        else if (phase == T7)
            phase_nxt = T0;
        else if (phase != IDLE)
            phase_nxt = phase_t'(phase + 4'd1);

        if (phase_nxt == T0) begin
            owner_nxt = OWN_NONE;
        end else if (phase_nxt == T3) begin
            if (boot && ldReq)
                owner_nxt = OWN_LD_WR;
            else if (cpuWr)
                owner_nxt = OWN_CPU_WR;
            else if (cpuRd)
                owner_nxt = OWN_CPU_RD;
            else if (!boot && ldReq)
                owner_nxt = OWN_LD_WR;
            else
                owner_nxt = OWN_NONE;
        end
    end

    assign own_write = (owner_nxt == OWN_CPU_WR) || (owner_nxt == OWN_LD_WR);

    // Next values of the registered pins, keyed on the phase being entered.
    always_comb begin
        a_nxt    = sramA;
        do_nxt   = sramDo;
        drv_nxt  = sramDrv;
        we_n_nxt = sramWe_n;
        oe_n_nxt = sramOe_n;
        case (phase_nxt)
            T0: begin
                a_nxt    = AW'(vid_to_phys(vidA));
                oe_n_nxt = 1'b0;
                drv_nxt  = 1'b0;
                we_n_nxt = 1'b1;
            end
            T3: begin
                we_n_nxt = 1'b1;
                case (owner_nxt)
                    OWN_CPU_WR: begin
                        a_nxt    = cpuA;
                        do_nxt   = cpuD;
                        drv_nxt  = 1'b1;
                        oe_n_nxt = 1'b1;
                    end
                    OWN_LD_WR: begin
                        a_nxt    = ldA;
                        do_nxt   = ldD;
                        drv_nxt  = 1'b1;
                        oe_n_nxt = 1'b1;
                    end
                    OWN_CPU_RD: begin
                        a_nxt    = cpuA;
                        drv_nxt  = 1'b0;
                        oe_n_nxt = 1'b0;
                    end
                    default: begin
                        drv_nxt  = 1'b0;
                        oe_n_nxt = 1'b1;
                    end
                endcase
            end
            T4, T5: we_n_nxt = !own_write;
            T6:     we_n_nxt = 1'b1;
            T7: begin
                drv_nxt  = 1'b0;
                oe_n_nxt = 1'b1;
                we_n_nxt = 1'b1;
            end
            default: ;
        endcase

        vidq_nxt = vidQ;
        if (phase == T2 && phase_nxt == T3)
            vidq_nxt = sramDi;

        cpuq_nxt = cpuQ;
        if (phase == T6 && phase_nxt == T7 && owner == OWN_CPU_RD)
            cpuq_nxt = sramDi;

        ack_nxt = (phase_nxt == T7) && (owner_nxt == OWN_LD_WR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sramA    <= '0;
            sramDo   <= '0;
            sramDrv  <= 1'b0;
            sramWe_n <= 1'b1;
            sramOe_n <= 1'b1;
            vidQ     <= 8'hFF;
            cpuQ     <= {DW{1'b1}};
            ldAck    <= 1'b0;
        end else begin
            sramA    <= a_nxt;
            sramDo   <= do_nxt;
            sramDrv  <= drv_nxt;
            sramWe_n <= we_n_nxt;
            sramOe_n <= oe_n_nxt;
            vidQ     <= vidq_nxt;
            cpuQ     <= cpuq_nxt;
            ldAck    <= ack_nxt;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: slot vectors from a table plus abort/reset/loader sequences.
module tb_sram_arbiter;

    logic        clock = 1'b0;
    logic        reset, sync;
    logic [13:0] vidA;
    logic [7:0]  vidQ;
    logic [17:0] cpuA, ldA, sramA;
    logic [7:0]  cpuD, cpuQ, ldD, sramDo, sramDi;
    logic        cpuRd, cpuWr, boot, ldReq, ldAck;
    logic        sramDrv, sramWe_n, sramOe_n;

    logic [7:0]  mem [0:262143];
    logic        we_lo_q = 1'b0;
    int          viol = 0;
    int          tests = 0;
    int          fails = 0;

    logic [7:0]  r_we, r_drv, r_oe, r_ack;
    logic [17:0] r_a    [8];
    logic [7:0]  r_vidq [8];
    logic [7:0]  r_cpuq [8];

    always #5 clock = ~clock;

    sram_arbiter dut (
        .clock(clock), .reset(reset), .sync(sync), .vidA(vidA), .vidQ(vidQ),
        .cpuA(cpuA), .cpuD(cpuD), .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuQ(cpuQ),
        .boot(boot), .ldReq(ldReq), .ldA(ldA), .ldD(ldD), .ldAck(ldAck),
        .sramA(sramA), .sramDo(sramDo), .sramDi(sramDi), .sramDrv(sramDrv),
        .sramWe_n(sramWe_n), .sramOe_n(sramOe_n)
    );

    // SRAM model: a write needs WE low for two full clocks, so truncated pulses are lost.
    assign sramDi = !sramOe_n ? mem[sramA] : 8'h00;
    always @(posedge clock) begin
        if (!sramWe_n && sramDrv && we_lo_q)
            mem[sramA] = sramDo;
        we_lo_q = !sramWe_n;
    end

    always @(negedge clock) begin
        if (reset && ((sramDrv && !sramOe_n) || (!sramWe_n && !sramDrv)))
            viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic        rd, wr, boot, ldreq;
        logic [17:0] cpua;
        logic [7:0]  cpud;
        logic [17:0] lda;
        logic [7:0]  ldd;
        logic [13:0] vida;
        logic [17:0] a0, a3;
        logic [7:0]  we, drv, oe;
        logic        ack;
        logic [7:0]  vidq, cpuq;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_slot();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int p = 0; p < 8; p++) begin
            if (p > 0) step();
            r_we[p]   = sramWe_n;
            r_drv[p]  = sramDrv;
            r_oe[p]   = sramOe_n;
            r_ack[p]  = ldAck;
            r_a[p]    = sramA;
            r_vidq[p] = vidQ;
            r_cpuq[p] = cpuQ;
        end
    endtask

    int acks;
    int idle_bad;

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
        mem[18'h3C000] = 8'hA5;
        mem[18'h34000] = 8'h11;
        mem[18'h35FFF] = 8'h22;
        mem[18'h3DFFF] = 8'h33;

        //            rd   wr   boot ldreq cpua       cpud   lda        ldd    vida      a0          a3          we     drv    oe     ack  vidq   cpuq
        vecs[0] = '{1'b0,1'b0,1'b0,1'b0,18'h00000,8'h00,18'h00000,8'h00,14'h2000,18'h3C000,18'h3C000,8'hFF,8'h00,8'hF8,1'b0,8'hA5,8'hFF};
        vecs[1] = '{1'b0,1'b1,1'b0,1'b0,18'h14123,8'h5A,18'h00000,8'h00,14'h0000,18'h34000,18'h14123,8'hCF,8'h78,8'hF8,1'b0,8'h11,8'hFF};
        vecs[2] = '{1'b1,1'b0,1'b0,1'b0,18'h14123,8'h00,18'h00000,8'h00,14'h1FFF,18'h35FFF,18'h14123,8'hFF,8'h00,8'h80,1'b0,8'h22,8'h5A};
        vecs[3] = '{1'b1,1'b1,1'b0,1'b0,18'h14124,8'hC3,18'h00000,8'h00,14'h3FFF,18'h3DFFF,18'h14124,8'hCF,8'h78,8'hF8,1'b0,8'h33,8'h5A};
        vecs[4] = '{1'b1,1'b0,1'b0,1'b0,18'h14124,8'h00,18'h00000,8'h00,14'h2000,18'h3C000,18'h14124,8'hFF,8'h00,8'h80,1'b0,8'hA5,8'hC3};
        vecs[5] = '{1'b0,1'b0,1'b0,1'b1,18'h00000,8'h00,18'h00010,8'h77,14'h0000,18'h34000,18'h00010,8'hCF,8'h78,8'hF8,1'b1,8'h11,8'hC3};
        vecs[6] = '{1'b1,1'b0,1'b1,1'b0,18'h14123,8'h00,18'h00000,8'h00,14'h2000,18'h3C000,18'h14123,8'hFF,8'h00,8'h80,1'b0,8'hA5,8'h5A};
        vecs[7] = '{1'b0,1'b0,1'b0,1'b0,18'h00000,8'h00,18'h00000,8'h00,14'h1FFF,18'h35FFF,18'h35FFF,8'hFF,8'h00,8'hF8,1'b0,8'h22,8'h5A};

        reset = 1'b0; sync = 1'b0; vidA = '0; cpuA = '0; cpuD = '0;
        cpuRd = 1'b0; cpuWr = 1'b0; boot = 1'b0; ldReq = 1'b0; ldA = '0; ldD = '0;
        step(); step();
        check("rst sramA", sramA, 18'h0);
        check("rst sramDo", sramDo, 8'h00);
        check("rst sramDrv", sramDrv, 1'b0);
        check("rst sramWe_n", sramWe_n, 1'b1);
        check("rst sramOe_n", sramOe_n, 1'b1);
        check("rst vidQ", vidQ, 8'hFF);
        check("rst cpuQ", cpuQ, 8'hFF);
        check("rst ldAck", ldAck, 1'b0);
        reset = 1'b1;
        step(); step(); step();
        check("idle before sync oe", sramOe_n, 1'b1);
        check("idle before sync addr", sramA, 18'h0);

        for (int i = 0; i < 8; i++) begin
            cpuRd = vecs[i].rd;   cpuWr = vecs[i].wr;   boot = vecs[i].boot;
            ldReq = vecs[i].ldreq; cpuA = vecs[i].cpua; cpuD = vecs[i].cpud;
            ldA = vecs[i].lda;    ldD = vecs[i].ldd;    vidA = vecs[i].vida;
            do_slot();
            check($sformatf("v%0d we_n", i), r_we, vecs[i].we);
            check($sformatf("v%0d drv", i), r_drv, vecs[i].drv);
            check($sformatf("v%0d oe_n", i), r_oe, vecs[i].oe);
            check($sformatf("v%0d addr t0", i), r_a[0], vecs[i].a0);
            check($sformatf("v%0d addr t3", i), r_a[3], vecs[i].a3);
            check($sformatf("v%0d ldAck", i), r_ack, vecs[i].ack ? 8'h80 : 8'h00);
            check($sformatf("v%0d vidQ t3", i), r_vidq[3], vecs[i].vidq);
            check($sformatf("v%0d cpuQ t7", i), r_cpuq[7], vecs[i].cpuq);
        end
        check("mem 14123", mem[18'h14123], 8'h5A);
        check("mem 14124", mem[18'h14124], 8'hC3);
        check("mem 00010", mem[18'h00010], 8'h77);

        // Boot mode: loader beats a pending CPU read, one write per slot.
        boot = 1'b1; cpuRd = 1'b1; cpuWr = 1'b0; cpuA = 18'h14123; ldReq = 1'b1;
        vidA = 14'h0000;
        acks = 0;
        for (int s = 0; s < 5; s++) begin
            if (s < 4) begin
                ldA = 18'(s);
                ldD = 8'hB0 + 8'(s);
            end else begin
                ldReq = 1'b0;
            end
            do_slot();
            acks += int'(r_ack[7]) + int'(r_ack[6:0] != 7'h0);
            if (s < 4) check($sformatf("boot slot%0d oe_n", s), r_oe, 8'hF8);
        end
        check("boot ack count", acks, 4);
        check("boot cpu read after loader", r_cpuq[7], 8'h5A);
        check("rom byte 0", mem[0], 8'hB0);
        check("rom byte 3", mem[3], 8'hB3);

        // Normal mode: CPU read starves the loader until it drops.
        boot = 1'b0; cpuRd = 1'b1; cpuA = 18'h14124; ldReq = 1'b1; ldA = 18'h00020; ldD = 8'h44;
        acks = 0;
        for (int s = 0; s < 3; s++) begin
            do_slot();
            acks += int'(r_ack != 8'h00);
        end
        check("cpu priority no ack", acks, 0);
        check("cpu priority cpuQ", r_cpuq[7], 8'hC3);
        cpuRd = 1'b0;
        do_slot();
        check("loader after cpu drops ack", r_ack, 8'h80);
        ldReq = 1'b0;
        check("loader after cpu drops mem", mem[18'h00020], 8'h44);

        // Sync injected at t4 of a CPU write.
        cpuWr = 1'b1; cpuA = 18'h20500; cpuD = 8'h99; vidA = 14'h2000;
        sync = 1'b1; step(); sync = 1'b0;
        step(); step(); step(); step();
        check("abort t4 we_n low", sramWe_n, 1'b0);
        sync = 1'b1; cpuWr = 1'b0;
        step();
        sync = 1'b0;
        check("abort t0 we_n", sramWe_n, 1'b1);
        check("abort t0 drv", sramDrv, 1'b0);
        check("abort t0 oe_n", sramOe_n, 1'b0);
        check("abort t0 addr", sramA, 18'h3C000);
        step(); step(); step();
        check("abort t3 vidQ", vidQ, 8'hA5);
        for (int k = 0; k < 4; k++) step();
        check("abort mem unchanged", mem[18'h20500], 8'h00);

        // Reset at t5 of a loader write.
        boot = 1'b1; ldReq = 1'b1; ldA = 18'h00100; ldD = 8'hEE;
        sync = 1'b1; step(); sync = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("reset t5 we_n low", sramWe_n, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("reset async we_n", sramWe_n, 1'b1);
        check("reset async drv", sramDrv, 1'b0);
        check("reset async vidQ", vidQ, 8'hFF);
        check("reset async cpuQ", cpuQ, 8'hFF);
        check("reset async addr", sramA, 18'h0);
        ldReq = 1'b0; boot = 1'b0;
        #3 reset = 1'b1;
        idle_bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (ldAck || !sramOe_n || sramA != 18'h0) idle_bad++;
        end
        check("idle after reset", idle_bad, 0);
        check("reset mem unchanged", mem[18'h00100], 8'h00);
        vidA = 14'h2000;
        do_slot();
        check("post reset addr t0", r_a[0], 18'h3C000);
        check("post reset vidQ", r_vidq[3], 8'hA5);
        check("post reset oe_n", r_oe, 8'hF8);

        check("pin invariants", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
